fetch_queue_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS core, placed between the instruction-memory port and the decode stage. Unlike the single-cycle combinational-ROM fetch, it talks to a variable-latency instruction memory through a request/response handshake. It buffers fetched instructions with their PC+4 in a QUEUE_DEPTH-entry FIFO, so decode stalls and memory latency are decoupled. Redirects from decode flush the queue and discard any in-flight response.

---
 rtl/fetch_queue_stage.sv | 133 +++++++++++++
 tb/tb_fetch_queue_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: one-outstanding request/response memory port feeding a PC+4-tagged FIFO.
// Optional FETCH_PERF_EN adds saturating bubble and flush counters.
module fetch_queue_stage #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         INSTR_WIDTH   = 32,
    parameter int                         QUEUE_DEPTH   = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
    input  logic                     i_PCSrcD,
    input  logic                     i_StallF,
    output logic                     o_IMemReq,
    output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
    input  logic                     i_IMemAck,
    input  logic                     i_IMemRValid,
    input  logic [INSTR_WIDTH-1:0]   i_IMemRData,
    output logic                     o_ValidF,
    output logic [INSTR_WIDTH-1:0]   o_InstrF,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4F
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              o_BubbleCnt,
    output logic [31:0]              o_FlushCnt
`endif
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]         FULL = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);

    logic [INSTR_WIDTH-1:0]   instr_q [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc4_q   [QUEUE_DEPTH];
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, iss_pc4_q, iss_pc4_d;
    logic                     outst_q, outst_d, disc_q, disc_d;
    logic                     accept, resp, push, pop;

    assign o_IMemReq  = ~i_RST & ~outst_q & ~i_PCSrcD & (count_q < FULL);
    assign o_IMemAddr = pc_q;
    assign o_ValidF   = (count_q != '0);
    assign o_InstrF   = o_ValidF ? instr_q[rd_ptr_q] : '0;
    assign o_PCPlus4F = o_ValidF ? pc4_q[rd_ptr_q] : '0;

    // Responses only count while a request is actually in flight.
    assign accept = o_IMemReq & i_IMemAck;
    assign resp   = i_IMemRValid & outst_q;
    assign pop    = o_ValidF & ~i_StallF & ~i_PCSrcD;
    assign push   = resp & ~disc_q & ~i_PCSrcD;

    always_comb begin
        pc_d      = pc_q;
        iss_pc4_d = iss_pc4_q;
        outst_d   = outst_q;
        disc_d    = disc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (i_PCSrcD) begin
            // A still-pending request must be swallowed when it finally returns.
            pc_d     = i_PCNextD;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            outst_d  = outst_q & ~resp;
            disc_d   = outst_q & ~resp;
        end else begin
            if (accept) begin
                pc_d      = pc_q + FOUR;
                iss_pc4_d = pc_q + FOUR;
                outst_d   = 1'b1;
            end
            if (resp) begin
                outst_d = 1'b0;
                disc_d  = 1'b0;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pc_q      <= RESET_PC;
            iss_pc4_q <= '0;
            outst_q   <= 1'b0;
            disc_q    <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            iss_pc4_q <= iss_pc4_d;
            outst_q   <= outst_d;
            disc_q    <= disc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Payload storage needs no reset; outputs are masked by the count.
    always_ff @(posedge i_CLK) begin
        if (push) begin
            instr_q[wr_ptr_q] <= i_IMemRData;
            pc4_q[wr_ptr_q]   <= iss_pc4_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_q, flush_q;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (!o_ValidF && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
            if (i_PCSrcD && flush_q != '1)   flush_q  <= flush_q + 32'd1;
        end
    end

    assign o_BubbleCnt = bubble_q;
    assign o_FlushCnt  = flush_q;
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage: queue-level reference model plus an in-order stream scoreboard.
module tb_fetch_queue_stage;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, pcsrc, stall, ack, rvalid;
  logic [31:0] target, addr, pc4o, rdata, instro;
  logic        req, vld;
`ifdef FETCH_PERF_EN
  logic [31:0] bub, flush;
`endif

  always #5 clk = ~clk;

  fetch_queue_stage dut (
    .i_CLK(clk), .i_RST(rst), .i_PCNextD(target), .i_PCSrcD(pcsrc), .i_StallF(stall),
    .o_IMemReq(req), .o_IMemAddr(addr), .i_IMemAck(ack), .i_IMemRValid(rvalid),
    .i_IMemRData(rdata), .o_ValidF(vld), .o_InstrF(instro), .o_PCPlus4F(pc4o)
`ifdef FETCH_PERF_EN
    , .o_BubbleCnt(bub), .o_FlushCnt(flush)
`endif
  );

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'h2002_0000 + (a >> 2);
  endfunction

  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_iss4, exp_pc4, mem_addr;
  bit          m_out, m_disc, mem_pend;
  int          mem_cd, lat, ack_pct, pops;
  int unsigned m_bub, m_flush;

  // One clock: drive at negedge, check at +1, advance memory and model at posedge.
  task automatic cyc();
    bit m_req, acc, rsp, dacc;
    logic [31:0] a_s, e_instr, e_pc4;
    ack    = ($urandom_range(99) < ack_pct);
    rvalid = mem_pend && mem_cd == 1;
    rdata  = rvalid ? mem_fn(mem_addr) : $urandom;
    #1;
    m_req = !rst && !m_out && !pcsrc && mq.size() < D;
    e_instr = 32'h0; e_pc4 = 32'h0;
    if (mq.size() != 0) begin e_instr = mq[0].instr; e_pc4 = mq[0].pc4; end
    check("req", req, m_req);
    check("addr", addr, m_pc);
    check("valid", vld, mq.size() != 0);
    check("instr", instro, e_instr);
    check("pc4", pc4o, e_pc4);
`ifdef FETCH_PERF_EN
    check("bubble_cnt", bub, m_bub);
    check("flush_cnt", flush, m_flush);
`endif
    if (!rst && !pcsrc && vld && !stall) begin
      check("stream_pc4", pc4o, exp_pc4);
      check("stream_instr", instro, mem_fn(pc4o - 32'd4));
      exp_pc4 += 32'd4;
      pops++;
    end
    dacc = req && ack;
    a_s  = addr;
    @(posedge clk);
    if (rst) mem_pend = 0;
    else begin
      if (mem_pend) begin
        if (rvalid) mem_pend = 0; else mem_cd--;
      end
      if (dacc) begin
        check("one_outstanding", mem_pend, 0);
        mem_pend = 1; mem_cd = lat; mem_addr = a_s;
      end
    end
    if (rst) begin
      mq.delete(); m_pc = 0; m_iss4 = 0; m_out = 0; m_disc = 0;
      exp_pc4 = 32'd4; m_bub = 0; m_flush = 0;
    end else begin
      if (mq.size() == 0) m_bub++;
      acc = m_req && ack;
      rsp = rvalid && m_out;
      if (pcsrc) begin
        m_flush++;
        mq.delete();
        m_pc = target;
        m_disc = m_out && !rvalid;
        m_out  = m_out && !rvalid;
        exp_pc4 = target + 32'd4;
      end else begin
        if (mq.size() != 0 && !stall) void'(mq.pop_front());
        if (rsp) begin
          if (m_disc) m_disc = 0; else mq.push_back('{rdata, m_iss4});
          m_out = 0;
        end
        if (acc) begin m_out = 1; m_iss4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int p0;
    bit found;
    rst = 1; pcsrc = 0; stall = 0; target = 0; ack = 0; rvalid = 0; rdata = 0;
    lat = 1; ack_pct = 100; pops = 0; mem_pend = 0; mem_cd = 0; mem_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mq.delete(); m_pc = 0; m_iss4 = 0; m_out = 0; m_disc = 0; exp_pc4 = 4; m_bub = 0; m_flush = 0;

    // Reset, then fill the queue under a held stall with zero-wait memory.
    stall = 1;
    cyc();
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 0) begin check("first_req", req, 1); check("first_addr", addr, 0); end
      if (c == 1) check("not_yet_valid", vld, 0);
      if (c == 2) begin
        check("first_valid", vld, 1);
        check("first_instr", instro, 32'h2002_0000);
        check("first_pc4", pc4o, 32'h4);
      end
      cyc();
    end
    #1;
    check("full_req_low", req, 0);
    check("full_head_instr", instro, 32'h2002_0000);
    check("full_head_pc4", pc4o, 32'h4);
    stall = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_valid", vld, 1);
      check("drain_pc4", pc4o, 32'(4 * (k + 1)));
      cyc();
    end

    // Redirect while a request is in flight and its response is not yet back.
    lat = 3;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (m_out && !(mem_pend && mem_cd == 1)) found = 1; else cyc();
    end
    check("find_outstanding", found, 1);
    pcsrc = 1; target = 32'h100;
    cyc();
    pcsrc = 0;
    #1;
    check("redir_empty", vld, 0);
    check("redir_addr", addr, 32'h100);
    repeat (40) cyc();

    // Redirect landing on the same cycle as a response.
    lat = 1;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (mem_pend && mem_cd == 1) found = 1; else cyc();
    end
    check("find_response", found, 1);
    pcsrc = 1; target = 32'h200;
    cyc();
    pcsrc = 0;
    #1;
    check("redir_rsp_empty", vld, 0);
    check("redir_rsp_req", req, 1);
    check("redir_rsp_addr", addr, 32'h200);
    repeat (10) cyc();

    // Slow memory: five-cycle response delay, twenty fetches.
    lat = 5;
    p0 = pops;
    for (int c = 0; c < 400 && pops - p0 < 20; c++) cyc();
    check("lat5_fetches", (pops - p0) >= 20, 1);

    // Wrap-around of the fetch PC.
    lat = 1;
    pcsrc = 1; target = 32'hFFFF_FFF4;
    cyc();
    pcsrc = 0;
    repeat (30) cyc();

    // Three back-to-back redirects from reset.
    rst = 1; cyc(); rst = 0;
    pcsrc = 1;
    for (int k = 0; k < 3; k++) begin target = 32'(k * 64); cyc(); end
    pcsrc = 0;
`ifdef FETCH_PERF_EN
    #1 check("flush_three", flush, 3);
`endif
    repeat (10) cyc();

    // Random mix of stalls, acks, latencies, redirects and resets.
    ack_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      lat   = $urandom_range(4, 1);
      stall = ($urandom_range(2) == 0);
      pcsrc = ($urandom_range(15) == 0);
      rst   = ($urandom_range(399) == 0);
      target = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      cyc();
    end
    rst = 0; pcsrc = 0; stall = 0;
    repeat (5) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
